pipe_buffer_ctrl: RTL and testbench

Responder side of the pipeline-start handshake. Consumes the PIP_RST / WE / RE strobes from the pipeline start FSM and generates write/read addresses and enables for a 512-entry circular delay buffer. Checks that the read pointer trails the write pointer by exactly PDEPTH once reading begins, and reports pipeline-valid and sticky fault status to the slow-control side.

---
 rtl/pipe_buffer_ctrl_if.sv | 41 ++++
 rtl/pipe_buffer_ctrl.sv | 129 ++++++++++++
 tb/tb_pipe_buffer_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_buffer_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_buffer_ctrl_if
// Handshake bundle between the pipeline start FSM and the delay-buffer
// controller.
//   pip_rst, we, re : strobes from the start FSM
//   pdepth          : programmed pipeline depth
//   wen/waddr       : buffer write port controls
//   ren/raddr       : buffer read port controls
//   occ             : current occupancy (write pointer minus read pointer)
//   pipe_valid      : pipeline running in steady state
//   underrun/overflow/depth_err : sticky fault status
// The master modport is the start-FSM / slow-control side; the slave
// modport is the controller.
// ---------------------------------------------------------------------------
interface pipe_buffer_ctrl_if #(
   parameter int AW = 9
);
   logic          pip_rst;
   logic          we;
   logic          re;
   logic [AW-1:0] pdepth;
   logic          wen;
   logic [AW-1:0] waddr;
   logic          ren;
   logic [AW-1:0] raddr;
   logic [AW-1:0] occ;
   logic          pipe_valid;
   logic          underrun;
   logic          overflow;
   logic          depth_err;

   modport master (
      output pip_rst, we, re, pdepth,
      input  wen, waddr, ren, raddr, occ, pipe_valid, underrun, overflow, depth_err
   );

   modport slave (
      input  pip_rst, we, re, pdepth,
      output wen, waddr, ren, raddr, occ, pipe_valid, underrun, overflow, depth_err
   );
endinterface

// File: rtl/pipe_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_buffer_ctrl
// Responder side of the pipeline-start handshake. Turns the PIP_RST/WE/RE
// strobes into write/read enables and addresses for a 2^AW-entry circular
// delay buffer, checks that reads trail writes by exactly PDEPTH entries once
// reading starts, and reports pipeline-valid plus sticky fault flags.
// Ports:
//   clk_i   : pipeline clock, rising edge
//   rst_b_i : asynchronous active-low reset
//   bus     : pipe_buffer_ctrl_if slave (strobes in, buffer controls/status out)
// ---------------------------------------------------------------------------
module pipe_buffer_ctrl #(
   parameter int AW = 9
) (
   input  logic                  clk_i,
   input  logic                  rst_b_i,
   pipe_buffer_ctrl_if.slave     bus
);

   typedef enum logic [1:0] {
      S_EMPTY  = 2'd0,
      S_FILL   = 2'd1,
      S_STEADY = 2'd2,
      S_FAULT  = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] wptr_q, rptr_q;
   logic [AW-1:0] waddr_q, raddr_q;
   logic          wen_q, ren_q;
   logic          pipe_valid_q;
   logic          underrun_q, overflow_q, depth_err_q;

   logic [AW-1:0] occ;
   logic          underrun_ev, overflow_ev, depth_err_ev, fault_ev;
   logic          do_wr, do_rd, depth_ok;

   assign occ      = wptr_q - rptr_q;
   assign depth_ok = (occ == bus.pdepth);

   // A read with nothing stored is suppressed even if a write arrives in the
   // same cycle: the written entry is not readable until the next cycle.
   assign underrun_ev = bus.re && (occ == '0);
   assign overflow_ev = bus.we && !bus.re && (occ == {AW{1'b1}});
   assign do_wr       = bus.we && !overflow_ev;
   assign do_rd       = bus.re && !underrun_ev;

   always_comb begin
      depth_err_ev = 1'b0;
      state_d      = state_q;
      case (state_q)
         S_EMPTY: begin
            // With a zero depth any write-only cycle already overshoots.
            if (bus.we && !bus.re) begin
               if (bus.pdepth == '0) depth_err_ev = 1'b1;
               else                  state_d      = S_FILL;
            end
         end
         S_FILL: begin
            if (bus.re) begin
               if (bus.we && depth_ok) state_d      = S_STEADY;
               else                    depth_err_ev = 1'b1;
            end
         end
         S_STEADY: begin
            // Checked every cycle so a PDEPTH change mid-run is caught too.
            if ((bus.re != bus.we) || !depth_ok) depth_err_ev = 1'b1;
         end
         default: state_d = S_FAULT;
      endcase
      fault_ev = underrun_ev || overflow_ev || depth_err_ev;
      if (fault_ev) state_d = S_FAULT;
   end

   always_ff @(posedge clk_i or negedge rst_b_i) begin
      if (!rst_b_i) begin
         state_q      <= S_EMPTY;
         wptr_q       <= '0;
         rptr_q       <= '0;
         waddr_q      <= '0;
         raddr_q      <= '0;
         wen_q        <= 1'b0;
         ren_q        <= 1'b0;
         pipe_valid_q <= 1'b0;
         underrun_q   <= 1'b0;
         overflow_q   <= 1'b0;
         depth_err_q  <= 1'b0;
      end else if (bus.pip_rst) begin
         state_q      <= S_EMPTY;
         wptr_q       <= '0;
         rptr_q       <= '0;
         waddr_q      <= '0;
         raddr_q      <= '0;
         wen_q        <= 1'b0;
         ren_q        <= 1'b0;
         pipe_valid_q <= 1'b0;
         underrun_q   <= 1'b0;
         overflow_q   <= 1'b0;
         depth_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         pipe_valid_q <= (state_d == S_STEADY);
         wen_q        <= do_wr;
         ren_q        <= do_rd;
         if (do_wr) begin
            waddr_q <= wptr_q;
            wptr_q  <= wptr_q + AW'(1);
         end
         if (do_rd) begin
            raddr_q <= rptr_q;
            rptr_q  <= rptr_q + AW'(1);
         end
         underrun_q  <= underrun_q  || underrun_ev;
         overflow_q  <= overflow_q  || overflow_ev;
         depth_err_q <= depth_err_q || depth_err_ev;
      end
   end

   assign bus.wen        = wen_q;
   assign bus.waddr      = waddr_q;
   assign bus.ren        = ren_q;
   assign bus.raddr      = raddr_q;
   assign bus.occ        = occ;
   assign bus.pipe_valid = pipe_valid_q;
   assign bus.underrun   = underrun_q;
   assign bus.overflow   = overflow_q;
   assign bus.depth_err  = depth_err_q;

endmodule

// File: tb/tb_pipe_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_buffer_ctrl
// Directed scenarios plus randomized strobe sequences for pipe_buffer_ctrl.
// A behavioural model (write/read counters, occupancy arithmetic and a few
// phase flags) predicts every output; it is compared once per cycle, and a
// few hand-computed literals pin the model at known points.
// ---------------------------------------------------------------------------
module tb_pipe_buffer_ctrl;

   localparam int AW    = 9;
   localparam int DEPTH = 512;

   logic clk;
   logic rst_b;

   pipe_buffer_ctrl_if #(.AW(AW)) bus_if ();

   pipe_buffer_ctrl #(.AW(AW)) dut (
      .clk_i   (clk),
      .rst_b_i (rst_b),
      .bus     (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec;
   int n_bad;

   // model state
   int m_w, m_r, m_waddr, m_raddr, m_pd;
   bit m_wen, m_ren, m_und, m_ovf, m_derr;
   bit m_fill, m_valid, m_fault;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int m_occ();
      return (m_w - m_r + DEPTH) % DEPTH;
   endfunction

   task automatic model_clear();
      m_w = 0; m_r = 0; m_waddr = 0; m_raddr = 0;
      m_wen = 0; m_ren = 0; m_und = 0; m_ovf = 0; m_derr = 0;
      m_fill = 0; m_valid = 0; m_fault = 0;
   endtask

   task automatic model_step(input bit pr, input bit w, input bit r);
      int occ;
      bit und, ovf, derr, go;
      if (pr) begin
         model_clear();
         return;
      end
      occ  = m_occ();
      und  = r && (occ == 0);
      ovf  = w && !r && (occ == DEPTH - 1);
      m_wen = w && !ovf;
      m_ren = r && !und;
      if (m_wen) begin m_waddr = m_w; m_w = (m_w + 1) % DEPTH; end
      if (m_ren) begin m_raddr = m_r; m_r = (m_r + 1) % DEPTH; end
      derr = 0;
      go   = 0;
      if (!m_fault) begin
         if (m_valid)
            derr = (w != r) || (occ != m_pd);
         else if (m_fill) begin
            if (r) begin
               if (w && occ == m_pd) go = 1;
               else                  derr = 1;
            end
         end else if (w && !r && m_pd == 0)
            derr = 1;
         if (und || ovf || derr) begin
            m_fault = 1; m_valid = 0; m_fill = 0;
         end else if (go) begin
            m_valid = 1; m_fill = 0;
         end else if (!m_valid && !m_fill && w && !r)
            m_fill = 1;
      end
      m_und  = m_und  || und;
      m_ovf  = m_ovf  || ovf;
      m_derr = m_derr || derr;
   endtask

   task automatic compare_all();
      chk("wen",        int'(bus_if.wen),        int'(m_wen));
      chk("ren",        int'(bus_if.ren),        int'(m_ren));
      if (m_wen) chk("waddr", int'(bus_if.waddr), m_waddr);
      if (m_ren) chk("raddr", int'(bus_if.raddr), m_raddr);
      chk("occ",        int'(bus_if.occ),        m_occ());
      chk("pipe_valid", int'(bus_if.pipe_valid), int'(m_valid));
      chk("underrun",   int'(bus_if.underrun),   int'(m_und));
      chk("overflow",   int'(bus_if.overflow),   int'(m_ovf));
      chk("depth_err",  int'(bus_if.depth_err),  int'(m_derr));
   endtask

   task automatic set_pd(input int pd);
      m_pd = pd;
      bus_if.pdepth = AW'(pd);
   endtask

   // Called at posedge+1; applies strobes for the next edge and checks after it.
   task automatic cycle(input bit pr, input bit w, input bit r);
      bus_if.pip_rst = pr;
      bus_if.we      = w;
      bus_if.re      = r;
      @(posedge clk);
      model_step(pr, w, r);
      #1;
      compare_all();
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_wen"},   int'(bus_if.wen),        0);
      chk({tag, "_waddr"}, int'(bus_if.waddr),      0);
      chk({tag, "_ren"},   int'(bus_if.ren),        0);
      chk({tag, "_raddr"}, int'(bus_if.raddr),      0);
      chk({tag, "_occ"},   int'(bus_if.occ),        0);
      chk({tag, "_valid"}, int'(bus_if.pipe_valid), 0);
      chk({tag, "_und"},   int'(bus_if.underrun),   0);
      chk({tag, "_ovf"},   int'(bus_if.overflow),   0);
      chk({tag, "_derr"},  int'(bus_if.depth_err),  0);
   endtask

   initial begin
      int pd, nfill, sel;
      n_vec = 0;
      n_bad = 0;
      model_clear();
      rst_b          = 1'b0;
      bus_if.pip_rst = 1'b0;
      bus_if.we      = 1'b0;
      bus_if.re      = 1'b0;
      set_pd(8);
      #22;
      check_all_zero("por");
      @(negedge clk);
      rst_b = 1'b1;

      // Nominal start: PIP_RST x10, WE x8, then RE=WE
      for (int i = 0; i < 10; i++) cycle(1, 0, 0);
      for (int i = 0; i < 8; i++)  cycle(0, 1, 0);
      chk("nom_fill_occ", int'(bus_if.occ), 8);
      cycle(0, 1, 1);
      chk("nom_occ",   int'(bus_if.occ),        8);
      chk("nom_valid", int'(bus_if.pipe_valid), 1);
      chk("nom_ren",   int'(bus_if.ren),        1);
      chk("nom_raddr", int'(bus_if.raddr),      0);
      chk("nom_waddr", int'(bus_if.waddr),      8);
      chk("nom_flags", int'({bus_if.underrun, bus_if.overflow, bus_if.depth_err}), 0);
      for (int i = 0; i < 5; i++) cycle(0, 1, 1);
      cycle(0, 0, 0);
      chk("nom_pause_valid", int'(bus_if.pipe_valid), 1);

      // Asynchronous reset mid-STEADY, checked before the next edge
      #2 rst_b = 1'b0;
      #1;
      check_all_zero("arst");
      model_clear();
      @(negedge clk);
      rst_b = 1'b1;

      // Wrap: PDEPTH=100, 600 steady cycles
      set_pd(100);
      cycle(1, 0, 0);
      for (int i = 0; i < 100; i++) cycle(0, 1, 0);
      for (int i = 1; i <= 600; i++) begin
         cycle(0, 1, 1);
         if (i == 412) begin
            chk("wrap_waddr511", int'(bus_if.waddr), 511);
            chk("wrap_raddr411", int'(bus_if.raddr), 411);
         end
         if (i == 413) chk("wrap_waddr0", int'(bus_if.waddr), 0);
         if (i == 512) chk("wrap_raddr511", int'(bus_if.raddr), 511);
         if (i == 513) begin
            chk("wrap_raddr0",  int'(bus_if.raddr), 0);
            chk("wrap_waddr100", int'(bus_if.waddr), 100);
         end
      end
      chk("wrap_occ",   int'(bus_if.occ),        100);
      chk("wrap_valid", int'(bus_if.pipe_valid), 1);

      // Simultaneous PIP_RST with WE=RE=1 in STEADY
      cycle(1, 1, 1);
      check_all_zero("pr_sim");

      // Depth error: one write short
      set_pd(8);
      for (int i = 0; i < 7; i++) cycle(0, 1, 0);
      cycle(0, 1, 1);
      chk("derr_flag",  int'(bus_if.depth_err),  1);
      chk("derr_valid", int'(bus_if.pipe_valid), 0);
      for (int i = 0; i < 10; i++) cycle(0, 1, 1);
      chk("derr_sticky", int'(bus_if.depth_err), 1);
      cycle(1, 0, 0);
      chk("derr_clr", int'(bus_if.depth_err), 0);

      // Underrun from EMPTY
      cycle(0, 0, 1);
      chk("und_flag", int'(bus_if.underrun), 1);
      chk("und_ren",  int'(bus_if.ren),      0);
      cycle(1, 0, 0);

      // Overflow: 511 writes fill the buffer, the 512th is refused
      for (int i = 0; i < 511; i++) cycle(0, 1, 0);
      chk("ovf_occ511", int'(bus_if.occ), 511);
      chk("ovf_none",   int'(bus_if.overflow), 0);
      cycle(0, 1, 0);
      chk("ovf_flag", int'(bus_if.overflow), 1);
      chk("ovf_wen",  int'(bus_if.wen),      0);
      chk("ovf_occ",  int'(bus_if.occ),      511);

      // Randomized start sequences and steady traffic
      for (int seg = 0; seg < 12; seg++) begin
         pd = int'($urandom_range(1, 40));
         set_pd(pd);
         cycle(1, 0, 0);
         nfill = pd;
         if ($urandom_range(0, 3) == 0) nfill = pd + int'($urandom_range(0, 2)) - 1;
         for (int i = 0; i < nfill; i++) cycle(0, 1, 0);
         for (int i = 0; i < 150; i++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 80)       cycle(0, 1, 1);
            else if (sel < 90)  cycle(0, 0, 0);
            else if (sel < 94)  cycle(0, 1, 0);
            else if (sel < 98)  cycle(0, 0, 1);
            else begin
               set_pd(int'($urandom_range(1, 40)));
               cycle(0, 1, 1);
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
